sigma_delta_scan_ctrl: RTL and testbench

Round-robin channel sequencer that time-shares one `sigma_delta_adc` between up to `NUM_CH` analog inputs through an external analog mux. It drives the mux select and discards the first `DISCARD` conversions after every switch so the decimator flushes stale history. It then captures one settled conversion per channel into a tagged result FIFO with a valid/ready output. It sits between `sigma_delta_adc` (`adc_output`/`adc_valid`) and the downstream sample consumer.

---
 rtl/sigma_delta_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sigma_delta_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_scan_ctrl
// Purpose  : Round-robin mux sequencer for one sigma_delta_adc with settle
//            discard and a tagged first-word-fall-through result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_delta_scan_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int WDTH       = 20,
    parameter int DISCARD    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic            ovf_clr,
    input  logic [WDTH-1:0] adc_output,
    input  logic            adc_valid,
    output logic [CW-1:0]   adc_chan_sel,
    output logic [WDTH-1:0] res_data,
    output logic [CW-1:0]   res_chan,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            scan_done,
    output logic            overflow
);

    localparam int         c_addr_w  = $clog2(FIFO_DEPTH);
    localparam logic [4:0] c_discard = 5'(DISCARD);
    localparam logic [c_addr_w:0] c_depth = (c_addr_w+1)'(FIFO_DEPTH);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_select  = 2'd1;
    localparam logic [1:0] c_settle  = 2'd2;
    localparam logic [1:0] c_capture = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_ptr;
    logic [CW-1:0] r_sel;
    logic [CW-1:0] r_last;
    logic [3:0]    r_disc_cnt;
    logic          r_scan_done;
    logic          r_overflow;

    logic [CW+WDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;

    logic [2*NUM_CH-1:0] w_rot;
    logic [CW:0]         w_off;
    logic [CW:0]         w_sum;
    logic                w_hit;
    logic [CW-1:0]       w_next_ch;
    logic [CW-1:0]       w_high;
    logic [CW-1:0]       w_sel_inc;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_full;

    // Rotate a doubled mask so the lowest set bit is the next channel at or
    // after the pointer, wrapping without a modulo on the index.
    always_comb begin
        w_rot  = {ch_mask, ch_mask} >> r_ptr;
        w_off  = '0;
        w_hit  = 1'b0;
        w_high = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_hit && w_rot[i]) begin
                w_hit = 1'b1;
                w_off = (CW+1)'(i);
            end
            if (ch_mask[i]) begin
                w_high = CW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + w_off;
        if (w_sum >= (CW+1)'(NUM_CH)) begin
            w_sum = w_sum - (CW+1)'(NUM_CH);
        end
        w_next_ch = CW'(w_sum);
        w_sel_inc = (r_sel == CW'(NUM_CH-1)) ? '0 : r_sel + CW'(1);
    end

    assign w_push_req = (r_state == c_capture) && enable && adc_valid;
    assign w_full     = (r_count == c_depth);
    assign w_pop      = res_valid && res_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_last      <= '0;
            r_disc_cnt  <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (enable && (|ch_mask)) begin
                        r_state <= c_select;
                    end
                end
                c_select: begin
                    if (!enable || !(|ch_mask)) begin
                        r_state <= c_idle;
                        r_ptr   <= '0;
                    end else begin
                        r_sel      <= w_next_ch;
                        r_last     <= w_high;
                        r_disc_cnt <= '0;
                        r_state    <= (DISCARD == 0) ? c_capture : c_settle;
                    end
                end
                c_settle: begin
                    if (!enable) begin
                        r_state <= c_idle;
                        r_ptr   <= '0;
                    end else if (adc_valid) begin
                        if (({1'b0, r_disc_cnt} + 5'd1) == c_discard) begin
                            r_state <= c_capture;
                        end else begin
                            r_disc_cnt <= r_disc_cnt + 4'd1;
                        end
                    end
                end
                c_capture: begin
                    if (!enable) begin
                        r_state <= c_idle;
                        r_ptr   <= '0;
                    end else if (adc_valid) begin
                        r_ptr       <= w_sel_inc;
                        r_scan_done <= (r_sel == r_last);
                        r_state     <= c_select;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // A pop on a full FIFO frees the slot for a same-edge push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_sel, adc_output};
                r_wr_ptr        <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_addr_w+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_addr_w+1)'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign adc_chan_sel         = r_sel;
    assign res_valid            = (r_count != '0);
    assign {res_chan, res_data} = r_mem[r_rd_ptr];
    assign scan_done            = r_scan_done;
    assign overflow             = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sigma_delta_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigma_delta_scan_ctrl
// Purpose  : Directed self-checking bench; DISCARD=2 and DISCARD=0 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          failures = 0;

    logic        en_a, ovf_clr_a, valid_a, ready_a;
    logic [3:0]  mask_a;
    logic [19:0] out_a, data_a;
    logic [1:0]  sel_a, chan_a;
    logic        rv_a, done_a, ovf_a;

    logic        en_b, valid_b;
    logic [19:0] out_b, data_b;
    logic [1:0]  sel_b, chan_b;
    logic        rv_b, done_b, ovf_b;

    always #5 clk = ~clk;

    sigma_delta_scan_ctrl #(.NUM_CH(4), .WDTH(20), .DISCARD(2), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .ch_mask(mask_a), .ovf_clr(ovf_clr_a),
        .adc_output(out_a), .adc_valid(valid_a), .adc_chan_sel(sel_a),
        .res_data(data_a), .res_chan(chan_a), .res_valid(rv_a), .res_ready(ready_a),
        .scan_done(done_a), .overflow(ovf_a)
    );

    sigma_delta_scan_ctrl #(.NUM_CH(4), .WDTH(20), .DISCARD(0), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .ch_mask(4'b0100), .ovf_clr(1'b0),
        .adc_output(out_b), .adc_valid(valid_b), .adc_chan_sel(sel_b),
        .res_data(data_b), .res_chan(chan_b), .res_valid(rv_b), .res_ready(1'b1),
        .scan_done(done_b), .overflow(ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        en_a = 1'b0; en_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0; ovf_clr_a = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic strobe_a(input logic [19:0] d);
        valid_a = 1'b1;
        out_a   = d;
        tick();
        valid_a = 1'b0;
    endtask

    // Entered with DUT A in SELECT; returns just after the capture edge.
    task automatic run_capture(input logic [1:0] ch, input logic [19:0] d,
                               input logic clr, input logic rdy);
        logic saved_rdy;
        tick();
        check("sel", {30'd0, sel_a}, {30'd0, ch});
        check("done_low", {31'd0, done_a}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            strobe_a(20'hF0000 | 20'(k));
            tick();
        end
        saved_rdy = ready_a;
        ready_a   = rdy;
        ovf_clr_a = clr;
        strobe_a(d);
        ready_a   = saved_rdy;
        ovf_clr_a = 1'b0;
    endtask

    initial begin
        logic [1:0]  chans [4];
        logic [19:0] drain [4];
        mask_a = 4'b0000; ready_a = 1'b0; out_a = '0; out_b = '0;
        chans[0] = 2'd0; chans[1] = 2'd1; chans[2] = 2'd3; chans[3] = 2'd0;
        drain[0] = 20'h02001; drain[1] = 20'h02002; drain[2] = 20'h02003; drain[3] = 20'h02008;

        // Reset values and idle strobes
        apply_reset();
        check("rst_sel",  {30'd0, sel_a}, 32'd0);
        check("rst_valid", {31'd0, rv_a}, 32'd0);
        check("rst_data", {12'd0, data_a}, 32'd0);
        check("rst_chan", {30'd0, chan_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_ovf",  {31'd0, ovf_a}, 32'd0);
        mask_a = 4'b1011;
        strobe_a(20'h0ABCD);
        tick();
        strobe_a(20'h0ABCE);
        tick();
        check("idle_no_entry", {31'd0, rv_a}, 32'd0);

        // Basic scan 0,1,3,0,1,3,0
        ready_a = 1'b1;
        en_a    = 1'b1;
        tick();
        for (int p = 0; p < 7; p++) begin
            run_capture(chans[p % 3 == 2 ? 2 : p % 3], 20'h01000 | 20'(chans[p % 3 == 2 ? 2 : p % 3]), 1'b0, 1'b1);
            check("scan_valid", {31'd0, rv_a}, 32'd1);
            check("scan_data", {12'd0, data_a}, {12'd0, 20'h01000 | 20'(chans[p % 3 == 2 ? 2 : p % 3])});
            check("scan_chan", {30'd0, chan_a}, {30'd0, chans[p % 3 == 2 ? 2 : p % 3]});
            check("scan_done", {31'd0, done_a}, {31'd0, (p % 3 == 2)});
        end
        en_a = 1'b0;
        tick();

        // DISCARD=0 instance, single channel 2
        en_b = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) begin
            tick();
            check("d0_sel", {30'd0, sel_b}, 32'd2);
            valid_b = 1'b1;
            out_b   = 20'h01002 + 20'(n * 16);
            tick();
            valid_b = 1'b0;
            check("d0_valid", {31'd0, rv_b}, 32'd1);
            check("d0_data", {12'd0, data_b}, {12'd0, 20'h01002 + 20'(n * 16)});
            check("d0_chan", {30'd0, chan_b}, 32'd2);
            check("d0_done", {31'd0, done_b}, 32'd1);
        end
        check("d0_ovf", {31'd0, ovf_b}, 32'd0);
        en_b = 1'b0;
        tick();

        // Overflow with a stalled consumer
        apply_reset();
        mask_a  = 4'b0001;
        ready_a = 1'b0;
        en_a    = 1'b1;
        tick();
        for (int n = 0; n < 4; n++) begin
            run_capture(2'd0, 20'h02000 + 20'(n), 1'b0, 1'b0);
            check("fill_head", {12'd0, data_a}, 32'h02000);
            check("fill_ovf", {31'd0, ovf_a}, 32'd0);
        end
        run_capture(2'd0, 20'h02004, 1'b0, 1'b0);
        check("ovf_set", {31'd0, ovf_a}, 32'd1);
        check("ovf_head", {12'd0, data_a}, 32'h02000);
        ovf_clr_a = 1'b1;
        tick();
        ovf_clr_a = 1'b0;
        check("ovf_clr", {31'd0, ovf_a}, 32'd0);
        run_capture(2'd0, 20'h02005, 1'b0, 1'b0);
        check("ovf_set2", {31'd0, ovf_a}, 32'd1);
        run_capture(2'd0, 20'h02006, 1'b1, 1'b0);
        check("ovf_set_wins", {31'd0, ovf_a}, 32'd1);
        ovf_clr_a = 1'b1;
        tick();
        ovf_clr_a = 1'b0;
        check("ovf_clr2", {31'd0, ovf_a}, 32'd0);

        // Full FIFO with pop on the capture edge
        run_capture(2'd0, 20'h02008, 1'b0, 1'b1);
        check("fpp_ovf", {31'd0, ovf_a}, 32'd0);
        for (int n = 0; n < 4; n++) begin
            check("drain_valid", {31'd0, rv_a}, 32'd1);
            check("drain_data", {12'd0, data_a}, {12'd0, drain[n]});
            ready_a = 1'b1;
            tick();
            ready_a = 1'b0;
        end
        check("drain_empty", {31'd0, rv_a}, 32'd0);

        // Abort during settle of channel 1
        apply_reset();
        mask_a  = 4'b1011;
        ready_a = 1'b1;
        en_a    = 1'b1;
        tick();
        run_capture(2'd0, 20'h01000, 1'b0, 1'b1);
        check("ab_first", {12'd0, data_a}, 32'h01000);
        tick();
        check("ab_sel1", {30'd0, sel_a}, 32'd1);
        strobe_a(20'hF0000);
        en_a = 1'b0;
        tick();
        check("ab_hold_sel", {30'd0, sel_a}, 32'd1);
        check("ab_no_entry", {31'd0, rv_a}, 32'd0);
        strobe_a(20'h01001);
        tick();
        check("ab_idle_ignored", {31'd0, rv_a}, 32'd0);
        en_a = 1'b1;
        tick();
        run_capture(2'd0, 20'h01000, 1'b0, 1'b1);
        check("ab_restart_chan", {30'd0, chan_a}, 32'd0);
        check("ab_restart_data", {12'd0, data_a}, 32'h01000);
        check("ab_restart_valid", {31'd0, rv_a}, 32'd1);
        en_a = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
